exc_ctrl: RTL

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// CP0-style exception controller: SR/Cause/EPC/PRId registers, interrupt and
// exception arbitration in the M stage, and eret return handling.
module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic        valid_m,
    input  logic [4:0]  exccode_m,
    input  logic        bd_m,
    input  logic [5:0]  hwint,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    input  logic        eret_m,
    output logic [31:0] dout,
    output logic        req,
    output logic        redirect,
    output logic [31:0] next_pc,
    output logic [31:0] epc
);

    localparam logic [31:0] PRID_VAL   = 32'h20181215;
    localparam logic [31:0] EXC_VECTOR = 32'h00004180;

    // HANDLER and SR.EXL are the same bit of state.
    typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] epc_sel;
    logic        exl;
    logic        int_req;
    logic        exc_req;
    logic        eret_take;
    logic        din_unused;

    assign exl = (state_q == HANDLER);

    // Gating with reset keeps every control output quiet while reset is held.
    assign int_req   = reset & ie_q & ~exl & (|(hwint & im_q));
    assign exc_req   = reset & ~exl & valid_m & (exccode_m != 5'd0);
    assign eret_take = reset & eret_m & exl;

    assign req      = int_req | exc_req;
    assign redirect = req | eret_take;
    assign epc      = epc_q;

    assign epc_sel    = bd_m ? (pc_m - 32'd4) : pc_m;
    assign din_unused = ^{din[1:0], epc_sel[1:0]};

    always_comb begin
        if (req) begin
            next_pc = EXC_VECTOR;
        end else if (eret_take) begin
            next_pc = epc_q;
        end else begin
            next_pc = 32'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        im_d      = im_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (req) begin
            state_d   = HANDLER;
            bd_d      = bd_m;
            epc_d     = {epc_sel[31:2], 2'b00};
            exccode_d = int_req ? 5'd0 : exccode_m;
        end else begin
            if (we) begin
                case (addr)
                    5'd12: begin
                        im_d    = din[15:10];
                        ie_d    = din[0];
                        state_d = din[1] ? HANDLER : RUN;
                    end
                    5'd14: epc_d = {din[31:2], 2'b00};
                    default: ;
                endcase
            end
            // eret overrides a same-cycle mtc0 to SR.EXL.
            if (eret_take) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            im_q      <= 6'd0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            im_q      <= im_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= hwint;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        case (addr)
            5'd12:   dout = {16'd0, im_q, 8'd0, exl, ie_q};
            5'd13:   dout = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
            5'd14:   dout = epc_q;
            5'd15:   dout = PRID_VAL;
            default: dout = 32'd0;
        endcase
    end

endmodule
